// File: rtl/music_sequencer.sv
// Plays a score from a registered 12-bit ROM as a square-wave tone on a buzzer pin.
// Each ROM word: [11:8] duration in beats (0 = end of score), [7:0] tone divisor (0 = rest).
module music_sequencer #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 12,
  parameter int BEAT_CYCLES = 5000000,
  parameter int TONE_SCALE  = 64
) (
  input  logic                  clk,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  loop_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  busy_o,
  output logic                  beep_o,
  output logic [7:0]            note_o,
  output logic                  done_o
);

  localparam int TW = 8 + $clog2(TONE_SCALE);
  localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST   = '1;
  localparam logic [BW-1:0]         BEAT_RELOAD = BW'(BEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, LATCH, PLAY} state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr_next;
  logic [7:0]              note_next;
  logic [3:0]              beats_left, beats_next;
  logic [BW-1:0]           beat_cnt, beat_next;
  logic [TW-1:0]           tone_cnt, tone_next;
  logic                    beep_next, done_next;
  logic [3:0]              duration;

  assign duration = data_i[11:8];
  assign busy_o   = (state != IDLE);

  // A rest never toggles, so its tone counter just idles at zero.
  function automatic logic [TW-1:0] tone_reload(input logic [7:0] n);
    if (n == 8'd0) begin
      return '0;
    end else begin
      return TW'(n) * TW'(TONE_SCALE) - TW'(1);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state      <= IDLE;
      addr_o     <= '0;
      note_o     <= '0;
      beats_left <= '0;
      beat_cnt   <= '0;
      tone_cnt   <= '0;
      beep_o     <= 1'b0;
      done_o     <= 1'b0;
    end else begin
      state      <= state_next;
      addr_o     <= addr_next;
      note_o     <= note_next;
      beats_left <= beats_next;
      beat_cnt   <= beat_next;
      tone_cnt   <= tone_next;
      beep_o     <= beep_next;
      done_o     <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    addr_next  = addr_o;
    note_next  = note_o;
    beats_next = beats_left;
    beat_next  = beat_cnt;
    tone_next  = tone_cnt;
    beep_next  = beep_o;
    done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = FETCH;
          addr_next  = '0;
        end
      end

      FETCH: state_next = LATCH;

      LATCH: begin
        if (duration == 4'd0) begin
          addr_next = '0;
          if (loop_i) begin
            state_next = FETCH;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
            note_next  = '0;
          end
        end else begin
          note_next  = data_i[7:0];
          beats_next = duration;
          beat_next  = BEAT_RELOAD;
          tone_next  = tone_reload(data_i[7:0]);
          beep_next  = 1'b0;
          state_next = PLAY;
        end
      end

      PLAY: begin
        if (tone_cnt == '0) begin
          tone_next = tone_reload(note_o);
          if (note_o != 8'd0) beep_next = ~beep_o;
        end else begin
          tone_next = tone_cnt - TW'(1);
        end

        if (beat_cnt == '0) begin
          beat_next  = BEAT_RELOAD;
          beats_next = beats_left - 4'd1;
          // Last beat of the note: silence the buzzer and move on, wrapping at the top of the ROM.
          if (beats_left == 4'd1) begin
            beep_next = 1'b0;
            if (addr_o != ADDR_LAST) begin
              addr_next  = addr_o + ADDR_WIDTH'(1);
              state_next = FETCH;
            end else begin
              addr_next = '0;
              if (loop_i) begin
                state_next = FETCH;
              end else begin
                state_next = IDLE;
                done_next  = 1'b1;
                note_next  = '0;
              end
            end
          end
        end else begin
          beat_next = beat_cnt - BW'(1);
        end
      end

      default: state_next = IDLE;
    endcase

    if (stop_i) begin
      state_next = IDLE;
      addr_next  = '0;
      note_next  = '0;
      beats_next = '0;
      beat_next  = '0;
      tone_next  = '0;
      beep_next  = 1'b0;
      done_next  = 1'b0;
    end
  end

endmodule

// File: tb/tb_music_sequencer.sv
// Scoreboard bench for music_sequencer: each scenario queues the expected per-cycle outputs,
// then starts playback and compares every cycle against the popped entry.
module tb_music_sequencer;

  localparam int AW   = 2;
  localparam int BEAT = 10;

  logic          clk = 1'b0;
  logic          rst_i, start_i, stop_i, loop_i;
  logic [AW-1:0] addr_o;
  logic [11:0]   data_i;
  logic          busy_o, beep_o, done_o;
  logic [7:0]    note_o;

  logic [11:0]   rom [4];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          busy;
    logic          beep;
    logic [7:0]    note;
    logic          chk_note;
    logic          done;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) data_i <= rom[addr_o];

  music_sequencer #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (12),
    .BEAT_CYCLES(BEAT),
    .TONE_SCALE (1)
  ) dut (
    .clk    (clk),
    .rst_i  (rst_i),
    .start_i(start_i),
    .stop_i (stop_i),
    .loop_i (loop_i),
    .addr_o (addr_o),
    .data_i (data_i),
    .busy_o (busy_o),
    .beep_o (beep_o),
    .note_o (note_o),
    .done_o (done_o)
  );

  task automatic push(input logic [AW-1:0] a, input logic b, input logic bp,
                      input logic [7:0] n, input logic cn, input logic d);
    exp_t e;
    e.addr = a; e.busy = b; e.beep = bp; e.note = n; e.chk_note = cn; e.done = d;
    exp_q.push_back(e);
  endtask

  task automatic push_idle(input int cycles, input logic done_first);
    for (int i = 0; i < cycles; i++) push('0, 1'b0, 1'b0, 8'd0, 1'b1, done_first && (i == 0));
  endtask

  task automatic push_fetch_latch(input logic [AW-1:0] a);
    push(a, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
    push(a, 1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
  endtask

  task automatic push_play(input logic [AW-1:0] a, input int cycles, input int n);
    for (int k = 1; k <= cycles; k++) begin
      logic bp;
      bp = (n == 0) ? 1'b0 : 1'(((k - 1) / n) % 2);
      push(a, 1'b1, bp, 8'(n), 1'b1, 1'b0);
    end
  endtask

  task automatic push_note(input logic [AW-1:0] a, input int dur, input int n);
    push_fetch_latch(a);
    push_play(a, dur * BEAT, n);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_i = 1'b1;
  endtask

  task automatic run_queue(input string name);
    exp_t e;
    int   cyc;
    cyc = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start_i = 1'b0;
      stop_i  = 1'b0;
      e = exp_q.pop_front();
      cyc++;
      n_checks++;
      if (addr_o !== e.addr) begin
        n_fails++;
        $display("[TB] FAIL %s.addr@%0d got %0d expected %0d", name, cyc, addr_o, e.addr);
      end
      n_checks++;
      if (busy_o !== e.busy) begin
        n_fails++;
        $display("[TB] FAIL %s.busy@%0d got %b expected %b", name, cyc, busy_o, e.busy);
      end
      n_checks++;
      if (beep_o !== e.beep) begin
        n_fails++;
        $display("[TB] FAIL %s.beep@%0d got %b expected %b", name, cyc, beep_o, e.beep);
      end
      n_checks++;
      if (done_o !== e.done) begin
        n_fails++;
        $display("[TB] FAIL %s.done@%0d got %b expected %b", name, cyc, done_o, e.done);
      end
      if (e.chk_note) begin
        n_checks++;
        if (note_o !== e.note) begin
          n_fails++;
          $display("[TB] FAIL %s.note@%0d got %0d expected %0d", name, cyc, note_o, e.note);
        end
      end
    end
  endtask

  task automatic test_reset();
    push_idle(3, 1'b0);
    run_queue("reset");
    rst_i = 1'b0;
    push_idle(2, 1'b0);
    run_queue("reset_release");
  endtask

  task automatic test_basic(input string name);
    loop_i = 1'b0;
    rom[0] = 12'h203;
    rom[1] = 12'h000;
    push_note(2'd0, 2, 3);
    push_fetch_latch(2'd1);
    push_idle(2, 1'b1);
    pulse_start();
    run_queue(name);
  endtask

  task automatic test_rest();
    loop_i = 1'b0;
    rom[0] = 12'h100;
    rom[1] = 12'h000;
    push_note(2'd0, 1, 0);
    push_fetch_latch(2'd1);
    push_idle(2, 1'b1);
    pulse_start();
    run_queue("rest");
  endtask

  task automatic test_loop();
    rom[0] = 12'h101;
    rom[1] = 12'h000;
    loop_i = 1'b1;
    for (int it = 0; it < 2; it++) begin
      push_note(2'd0, 1, 1);
      push_fetch_latch(2'd1);
    end
    push_note(2'd0, 1, 1);
    pulse_start();
    run_queue("loop");
    loop_i = 1'b0;
    push_fetch_latch(2'd1);
    push_idle(2, 1'b1);
    run_queue("loop_exit");
  endtask

  task automatic test_stop();
    loop_i = 1'b0;
    rom[0] = 12'hF05;
    rom[1] = 12'h000;
    push_fetch_latch(2'd0);
    push_play(2'd0, 7, 5);
    pulse_start();
    run_queue("stop_play");
    stop_i  = 1'b1;
    start_i = 1'b1;
    push_idle(4, 1'b0);
    run_queue("stop_abort");
    stop_i  = 1'b1;
    start_i = 1'b1;
    push_idle(3, 1'b0);
    run_queue("stop_idle_start");
  endtask

  task automatic test_reset_mid_play();
    loop_i = 1'b0;
    rom[0] = 12'h203;
    rom[1] = 12'h000;
    push_fetch_latch(2'd0);
    push_play(2'd0, 8, 3);
    pulse_start();
    run_queue("midreset_play");
    rst_i = 1'b1;
    push_idle(2, 1'b0);
    run_queue("midreset_held");
    rst_i = 1'b0;
  endtask

  task automatic test_wrap();
    loop_i = 1'b0;
    for (int i = 0; i < 4; i++) rom[i] = 12'h101;
    for (int i = 0; i < 4; i++) push_note(AW'(i), 1, 1);
    push_idle(2, 1'b1);
    pulse_start();
    run_queue("wrap");
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rom[i] = 12'h000;
    rst_i   = 1'b1;
    start_i = 1'b0;
    stop_i  = 1'b0;
    loop_i  = 1'b0;
    $display("[TB] music_sequencer bench starting");
    test_reset();
    test_basic("basic");
    test_rest();
    test_loop();
    test_stop();
    test_reset_mid_play();
    test_basic("restart");
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
